mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency instruction/data SRAM between the IF stage (instruction fetch) and the MEM stage (load/store driven by MEM_R_EN/MEM_W_EN from the decode controller).
- Sequences each access with a req/ready handshake and generates the pipeline freeze signals that hold IF or the whole pipe until the access completes.
- Sits between the pipeline registers and the memory wrapper.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/arb_wdog_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM SRAM port arbiter: FSM encoding and grant IDs.
// MEM_ARB_WDOG_EN enables the access watchdog (see arb_wdog_counter).
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_MEM_ACC  = 3'd1,
    ARB_IF_ACC   = 3'd2,
    ARB_MEM_DONE = 3'd3,
    ARB_IF_DONE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  // Watchdog counter is never narrower than 8 bits.
  function automatic int wdog_cnt_w(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline + SRAM side signals of the arbiter; slave = arbiter, master = environment.
// arb_err exists only when MEM_ARB_WDOG_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              flush;
  logic              freeze_if;
  logic              freeze_pipe;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;
`ifdef MEM_ARB_WDOG_EN
  logic              arb_err;

  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, flush,
           sram_rdata, sram_ready,
    output if_rdata, if_done, mem_rdata, mem_done, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata, arb_err
  );
  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, flush,
           sram_rdata, sram_ready,
    input  if_rdata, if_done, mem_rdata, mem_done, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata, arb_err
  );
`else
  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, flush,
           sram_rdata, sram_ready,
    output if_rdata, if_done, mem_rdata, mem_done, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, flush,
           sram_rdata, sram_ready,
    input  if_rdata, if_done, mem_rdata, mem_done, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata
  );
`endif
endinterface

// File: rtl/arb_wdog_counter.sv
// Access watchdog: counts stalled SRAM cycles and flags expiry on the WDOG_CYC-th one.
// Present only when MEM_ARB_WDOG_EN is defined.
`ifdef MEM_ARB_WDOG_EN
module arb_wdog_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int WDOG_CYC = 255,
  localparam int CNT_W    = wdog_cnt_w(WDOG_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clr,
  output logic expired
);
  logic [CNT_W-1:0] cnt;

  assign expired = active & ~clr & (cnt == CNT_W'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (!active | clr | expired) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one variable-latency SRAM port.
// MEM_ARB_WDOG_EN adds a watchdog that aborts hung accesses and raises sticky arb_err.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_WDOG_EN
  ,
  parameter int WDOG_CYC = 255
`endif
) (
  input logic           clk,
  input logic           rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state, state_nxt;
  gnt_e              last_grant;
  logic              discard;
  logic              mem_pend, gnt_mem, acc_end, wdog_to;
  logic              if_done, mem_done, freeze_pipe;
  logic              sram_req_q, sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q, if_rdata_q, mem_rdata_q, acc_rdata;

  assign mem_pend = bus.mem_r_en | bus.mem_w_en;
  // MEM wins a tie unless it won the previous access.
  assign gnt_mem  = mem_pend & (~bus.if_req | (last_grant == GNT_IF));

`ifdef MEM_ARB_WDOG_EN
  logic in_acc, arb_err_q;

  assign in_acc = (state == ARB_MEM_ACC) | (state == ARB_IF_ACC);

  arb_wdog_counter #(.WDOG_CYC(WDOG_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .active  (in_acc),
    .clr     (bus.sram_ready),
    .expired (wdog_to)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         arb_err_q <= 1'b0;
    else if (wdog_to) arb_err_q <= 1'b1;
  end

  assign bus.arb_err = arb_err_q;
`else
  assign wdog_to = 1'b0;
`endif

  // A watchdog abort completes the access with zero data so the pipe drains.
  assign acc_end   = bus.sram_ready | wdog_to;
  assign acc_rdata = bus.sram_ready ? bus.sram_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if_done   = 1'b0;
    mem_done  = 1'b0;
    case (state)
      ARB_IDLE:     if (mem_pend | bus.if_req) state_nxt = gnt_mem ? ARB_MEM_ACC : ARB_IF_ACC;
      ARB_MEM_ACC:  if (acc_end) state_nxt = ARB_MEM_DONE;
      ARB_IF_ACC:   if (acc_end) state_nxt = ARB_IF_DONE;
      ARB_MEM_DONE: begin
        mem_done  = 1'b1;
        state_nxt = ARB_IDLE;
      end
      ARB_IF_DONE: begin
        if_done   = ~discard;
        state_nxt = ARB_IDLE;
      end
      default:      state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      discard      <= 1'b0;
      last_grant   <= GNT_IF;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (mem_pend | bus.if_req) begin
            sram_req_q   <= 1'b1;
            sram_we_q    <= gnt_mem & bus.mem_w_en;
            sram_addr_q  <= gnt_mem ? bus.mem_addr : bus.if_addr;
            sram_wdata_q <= gnt_mem ? bus.mem_wdata : '0;
          end
        end
        ARB_MEM_ACC: begin
          if (acc_end) begin
            sram_req_q  <= 1'b0;
            sram_we_q   <= 1'b0;
            mem_rdata_q <= acc_rdata;
            last_grant  <= GNT_MEM;
          end
        end
        ARB_IF_ACC: begin
          if (bus.flush) discard <= 1'b1;
          if (acc_end) begin
            sram_req_q <= 1'b0;
            sram_we_q  <= 1'b0;
            last_grant <= GNT_IF;
            // A stale fetch still finishes on the SRAM but never lands in if_rdata.
            if (!(discard | bus.flush)) if_rdata_q <= acc_rdata;
          end
        end
        ARB_IF_DONE: discard <= 1'b0;
        default: ;
      endcase
    end
  end

  assign freeze_pipe     = mem_pend & ~mem_done;
  assign bus.freeze_pipe = freeze_pipe;
  assign bus.freeze_if   = freeze_pipe | (bus.if_req & ~if_done);
  assign bus.if_done     = if_done;
  assign bus.mem_done    = mem_done;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.sram_req    = sram_req_q;
  assign bus.sram_we     = sram_we_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_wdata  = sram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: SRAM accesses and done pulses are checked
// against queued expectations by monitors; directed stimulus covers grant order, flush, reset.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_WDOG_EN
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WDOG_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  resp_t resp_q[$];
  acc_t  acc_q[$];
  int    wait_cfg = 0;
  bit    sram_hang = 1'b0;
  int    ws = 0;
  resp_t mon_r;
  acc_t  mon_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sram_data(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h100: return 32'h12345678;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // SRAM model: ready after wait_cfg wait states; checks each accepted access.
  always @(negedge clk) begin
    if (!rst) begin
      bus.sram_ready = 1'b0;
      ws = 0;
    end else if (bus.sram_req && !bus.sram_ready) begin
      if (!sram_hang && ws == wait_cfg) begin
        bus.sram_ready = 1'b1;
        bus.sram_rdata = sram_data(bus.sram_addr);
        if (acc_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_access: addr %h we %b, none expected", bus.sram_addr, bus.sram_we);
        end else begin
          mon_a = acc_q.pop_front();
          chk("acc_we", {31'b0, bus.sram_we}, {31'b0, mon_a.we});
          chk("acc_addr", bus.sram_addr, mon_a.addr);
          if (mon_a.we) chk("acc_wdata", bus.sram_wdata, mon_a.wdata);
        end
      end else begin
        ws++;
      end
    end else begin
      bus.sram_ready = 1'b0;
      ws = 0;
    end
  end

  // Done monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst && (bus.if_done || bus.mem_done)) begin
      if (resp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: if_done %b mem_done %b, none expected", bus.if_done, bus.mem_done);
      end else begin
        mon_r = resp_q.pop_front();
        chk("done_kind", {31'b0, bus.mem_done}, {31'b0, mon_r.is_mem});
        chk("done_rdata", mon_r.is_mem ? bus.mem_rdata : bus.if_rdata, mon_r.data);
      end
    end
  end

  task automatic wait_done(input bit is_mem, output int lat, output int frz, output int reqc);
    lat  = -1;
    frz  = 0;
    reqc = 0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (is_mem ? bus.freeze_pipe : bus.freeze_if) frz++;
      if (bus.sram_req) reqc++;
      if (is_mem ? bus.mem_done : bus.if_done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, frz, reqc;
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    bus.flush = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_sram_req", {31'b0, bus.sram_req}, 0);
    chk("rst_sram_we", {31'b0, bus.sram_we}, 0);
    chk("rst_if_done", {31'b0, bus.if_done}, 0);
    chk("rst_mem_done", {31'b0, bus.mem_done}, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk("rst_freeze_if", {31'b0, bus.freeze_if}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Load, 3 wait states
    wait_cfg = 3;
    acc_q.push_back('{1'b0, 32'h100, 32'h0});
    resp_q.push_back('{1'b1, 32'h12345678});
    bus.mem_r_en = 1'b1; bus.mem_addr = 32'h100;
    wait_done(1'b1, lat, frz, reqc);
    chk("load_latency", 32'(lat), 5);
    chk("load_freeze_pipe_cycles", 32'(frz), 5);
    chk("load_req_cycles", 32'(reqc), 4);
    bus.mem_r_en = 1'b0;
    @(negedge clk);

    // Zero-wait fetch (last_grant becomes IF)
    wait_cfg = 0;
    acc_q.push_back('{1'b0, 32'h10, 32'h0});
    resp_q.push_back('{1'b0, 32'hDEADBEEF});
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    wait_done(1'b0, lat, frz, reqc);
    chk("fetch_latency", 32'(lat), 2);
    chk("fetch_freeze_if_cycles", 32'(frz), 2);
    chk("fetch_req_cycles", 32'(reqc), 1);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Simultaneous after IF: store first, then fetch
    acc_q.push_back('{1'b1, 32'h200, 32'hCAFEF00D});
    acc_q.push_back('{1'b0, 32'h14, 32'h0});
    resp_q.push_back('{1'b1, 32'hA5A50200});
    resp_q.push_back('{1'b0, 32'hA5A50014});
    bus.mem_w_en = 1'b1; bus.mem_addr = 32'h200; bus.mem_wdata = 32'hCAFEF00D;
    bus.if_req = 1'b1;   bus.if_addr = 32'h14;
    wait_done(1'b1, lat, frz, reqc);
    chk("pair1_store_latency", 32'(lat), 2);
    bus.mem_w_en = 1'b0; bus.mem_wdata = '0;
    wait_done(1'b0, lat, frz, reqc);
    chk("pair1_fetch_latency", 32'(lat), 3);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Lone store makes MEM the last grant
    acc_q.push_back('{1'b1, 32'h204, 32'h0BADF00D});
    resp_q.push_back('{1'b1, 32'hA5A50204});
    bus.mem_w_en = 1'b1; bus.mem_addr = 32'h204; bus.mem_wdata = 32'h0BADF00D;
    wait_done(1'b1, lat, frz, reqc);
    chk("store_latency", 32'(lat), 2);
    bus.mem_w_en = 1'b0; bus.mem_wdata = '0;
    @(negedge clk);

    // Simultaneous after MEM: fetch first, then load
    acc_q.push_back('{1'b0, 32'h18, 32'h0});
    acc_q.push_back('{1'b0, 32'h300, 32'h0});
    resp_q.push_back('{1'b0, 32'hA5A50018});
    resp_q.push_back('{1'b1, 32'hA5A50300});
    bus.mem_r_en = 1'b1; bus.mem_addr = 32'h300;
    bus.if_req = 1'b1;   bus.if_addr = 32'h18;
    wait_done(1'b0, lat, frz, reqc);
    chk("pair2_fetch_latency", 32'(lat), 2);
    bus.if_req = 1'b0;
    wait_done(1'b1, lat, frz, reqc);
    chk("pair2_load_latency", 32'(lat), 3);
    bus.mem_r_en = 1'b0;
    @(negedge clk);

    // Flush mid-fetch, 2 wait states; address change after grant is ignored
    wait_cfg = 2;
    acc_q.push_back('{1'b0, 32'h20, 32'h0});
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    @(negedge clk);
    bus.flush = 1'b1; bus.if_addr = 32'h99;
    @(negedge clk);
    bus.flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("flush_if_rdata_kept", bus.if_rdata, 32'hA5A50018);
    chk("flush_req_dropped", {31'b0, bus.sram_req}, 0);
    chk("flush_access_done", 32'(acc_q.size()), 0);
    @(negedge clk);

    // Fetch after flush: FSM back in IDLE and discard cleared
    wait_cfg = 0;
    acc_q.push_back('{1'b0, 32'h24, 32'h0});
    resp_q.push_back('{1'b0, 32'hA5A50024});
    bus.if_req = 1'b1; bus.if_addr = 32'h24;
    wait_done(1'b0, lat, frz, reqc);
    chk("post_flush_fetch_latency", 32'(lat), 2);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset during MEM_ACC
    wait_cfg = 5;
    bus.mem_r_en = 1'b1; bus.mem_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", {31'b0, bus.sram_req}, 1);
    rst = 1'b0; bus.mem_r_en = 1'b0;
    #1;
    chk("async_rst_sram_req", {31'b0, bus.sram_req}, 0);
    chk("async_rst_mem_done", {31'b0, bus.mem_done}, 0);
    chk("async_rst_freeze_pipe", {31'b0, bus.freeze_pipe}, 0);
    chk("async_rst_mem_rdata", bus.mem_rdata, 0);
    chk("async_rst_sram_addr", bus.sram_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wait_cfg = 0;
    acc_q.push_back('{1'b0, 32'h28, 32'h0});
    resp_q.push_back('{1'b0, 32'hA5A50028});
    bus.if_req = 1'b1; bus.if_addr = 32'h28;
    wait_done(1'b0, lat, frz, reqc);
    chk("post_rst_fetch_latency", 32'(lat), 2);
    bus.if_req = 1'b0;
    @(negedge clk);

`ifdef MEM_ARB_WDOG_EN
    // Hung SRAM: watchdog aborts after 4 cycles with zero data
    sram_hang = 1'b1;
    resp_q.push_back('{1'b1, 32'h0});
    bus.mem_r_en = 1'b1; bus.mem_addr = 32'h500;
    wait_done(1'b1, lat, frz, reqc);
    chk("wdog_latency", 32'(lat), 5);
    chk("wdog_arb_err", {31'b0, bus.arb_err}, 1);
    bus.mem_r_en = 1'b0;
    sram_hang = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("wdog_arb_err_sticky", {31'b0, bus.arb_err}, 1);
`endif

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 0);
    chk("acc_queue_drained", 32'(acc_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
